// File: rtl/lsu_axi_bridge.sv
// Load/store bridge: MEM-stage byte/half/word accesses -> word-aligned AXI4-Lite master single transfers.
// Latency: stall = 1 issue cycle + master busy duration + 1; load_data is valid in the DONE cycle.
// Backpressure: stall holds the pipeline while a transfer is outstanding; a misaligned access never stalls and is never issued.
//
// Ports:
//   clk, rst                             clock and synchronous active-high reset
//   mem_read_en/mem_write_en/mem_addr/mem_wdata/mem_funct3   MEM-stage request, held until stall drops
//   stall, load_data, misaligned         pipeline-side results
//   write_start/write_addr/write_data/write_strobe/write_busy  master write port
//   read_start/read_addr/read_data/read_busy                   master read port
module lsu_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [2:0]            mem_funct3,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned,
    output logic                  write_start,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [3:0]            write_strobe,
    input  logic                  write_busy,
    output logic                  read_start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] W_ISSUE = 3'd1;
    localparam logic [2:0] W_WAIT  = 3'd2;
    localparam logic [2:0] R_ISSUE = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic [1:0]  ld_lo;     // byte offset of the outstanding load
    logic [2:0]  ld_funct3; // width/sign of the outstanding load

    logic [1:0]  addr_lo;
    logic        size_byte;
    logic        size_half;
    logic        req;
    logic        req_misaligned;
    logic        accept;
    logic [3:0]  st_strobe;
    logic [31:0] st_data;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign addr_lo   = mem_addr[1:0];
    // funct3[1:0] encodes the size for both loads and stores; 11 falls through to word.
    assign size_byte = (mem_funct3[1:0] == 2'b00);
    assign size_half = (mem_funct3[1:0] == 2'b01);
    assign req       = mem_read_en | mem_write_en;

    assign req_misaligned = (size_half && addr_lo[0]) ||
                            (!size_byte && !size_half && (addr_lo != 2'b00));

    assign accept    = (state == IDLE) && req && !req_misaligned;
    assign word_addr = {mem_addr[ADDR_WIDTH-1:2], 2'b00};

    // Stall is combinational so the request is held from its very first cycle.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:                              stall = accept;
                W_ISSUE, W_WAIT, R_ISSUE, R_WAIT:  stall = 1'b1;
                default:                           stall = 1'b0;
            endcase
        end
    end

    // Store lane placement: replicate the narrow datum across the word and
    // let the strobe pick the lane the memory actually updates.
    always_comb begin
        st_strobe = 4'b1111;
        st_data   = mem_wdata;
        if (size_byte) begin
            st_strobe = 4'b0001 << addr_lo;
            st_data   = {4{mem_wdata[7:0]}};
        end else if (size_half) begin
            st_strobe = 4'b0011 << addr_lo;
            st_data   = {2{mem_wdata[15:0]}};
        end
    end

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'h0, b};
            3'b101:  extend_load = {16'h0, h};
            default: extend_load = word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ld_lo        <= 2'b00;
            ld_funct3    <= 3'b000;
            load_data    <= '0;
            misaligned   <= 1'b0;
            write_start  <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            write_strobe <= 4'b0000;
            read_start   <= 1'b0;
            read_addr    <= '0;
        end else begin
            write_start <= 1'b0;
            read_start  <= 1'b0;
            misaligned  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && req_misaligned) begin
                        misaligned <= 1'b1;
                    end else if (mem_write_en) begin
                        // Write has priority when both enables are high.
                        write_addr   <= word_addr;
                        write_data   <= st_data;
                        write_strobe <= st_strobe;
                        write_start  <= 1'b1;
                        state        <= W_ISSUE;
                    end else if (mem_read_en) begin
                        read_addr  <= word_addr;
                        ld_lo      <= addr_lo;
                        ld_funct3  <= mem_funct3;
                        read_start <= 1'b1;
                        state      <= R_ISSUE;
                    end
                end
                // The master may raise busy a cycle after start; do not
                // mistake the pre-busy gap for completion.
                W_ISSUE: if (write_busy) state <= W_WAIT;
                W_WAIT:  if (!write_busy) state <= DONE;
                R_ISSUE: if (read_busy) state <= R_WAIT;
                R_WAIT: begin
                    if (!read_busy) begin
                        load_data <= extend_load(read_data, ld_lo, ld_funct3);
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Bench for lsu_axi_bridge: directed load/store vectors against a small master/memory model.
module tb_lsu_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic        stall, misaligned;
    logic [31:0] load_data;
    logic        write_start, write_busy;
    logic [31:0] write_addr, write_data;
    logic [3:0]  write_strobe;
    logic        read_start, read_busy;
    logic [31:0] read_addr, read_data;

    always #5 clk = ~clk;

    lsu_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .stall(stall), .load_data(load_data), .misaligned(misaligned),
        .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .write_busy(write_busy),
        .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
        .read_busy(read_busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- master + memory model ----------------
    localparam int BUSY_CYCLES = 3;
    logic [31:0] mem [0:15];
    int          wc, rc;
    logic [31:0] w_addr_l, w_data_l;
    logic [3:0]  w_strb_l;
    int          wr_busy_rises = 0, rd_busy_rises = 0;
    logic        wb_q = 1'b0, rb_q = 1'b0;

    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            write_busy <= 1'b0; read_busy <= 1'b0; wc <= 0; rc <= 0;
            read_data <= 32'h0;
        end else begin
            if (write_start) begin
                write_busy <= 1'b1; wc <= BUSY_CYCLES;
                w_addr_l <= write_addr; w_data_l <= write_data; w_strb_l <= write_strobe;
            end else if (write_busy) begin
                if (wc == 1) begin
                    write_busy <= 1'b0;
                    for (int b = 0; b < 4; b++)
                        if (w_strb_l[b]) mem[w_addr_l[5:2]][8*b +: 8] <= w_data_l[8*b +: 8];
                end
                wc <= wc - 1;
            end
            if (read_start) begin
                read_busy <= 1'b1; rc <= BUSY_CYCLES;
                read_data <= mem[read_addr[5:2]];
            end else if (read_busy) begin
                if (rc == 1) read_busy <= 1'b0;
                rc <= rc - 1;
            end
        end
    end

    always @(posedge clk) begin
        wb_q <= write_busy; rb_q <= read_busy;
        if (write_busy && !wb_q) wr_busy_rises++;
        if (read_busy && !rb_q) rd_busy_rises++;
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    wr_t         q_wr[$];
    logic [31:0] q_rd[$];
    logic [31:0] q_done[$];
    int          q_mis[$];
    logic        prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (write_start) begin
                if (q_wr.size() == 0) chk("unexpected_write_start", 32'd1, 32'd0);
                else begin
                    wr_t e;
                    e = q_wr.pop_front();
                    chk("write_addr", write_addr, e.addr);
                    chk("write_data", write_data, e.data);
                    chk("write_strobe", {28'h0, write_strobe}, {28'h0, e.strb});
                end
            end
            if (read_start) begin
                if (q_rd.size() == 0) chk("unexpected_read_start", 32'd1, 32'd0);
                else chk("read_addr", read_addr, q_rd.pop_front());
            end
            if (misaligned) begin
                if (q_mis.size() == 0) chk("unexpected_misaligned", 32'd1, 32'd0);
                else begin
                    void'(q_mis.pop_front());
                    chk("misaligned_no_stall", {31'h0, stall}, 32'd0);
                end
            end
            if (prev_stall && !stall) begin
                if (q_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("load_data", load_data, q_done.pop_front());
            end
            prev_stall = stall;
        end
    end

    // ---------------- driver ----------------
    logic [31:0] last_load = 32'h0;

    task automatic idle_inputs();
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_funct3 = 3'b000;
    endtask

    // Issue one request, push the hand-computed expectations, hold it until stall drops.
    task automatic do_req(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] es, input logic [31:0] ed,
                          input logic [31:0] el, input logic mis);
        bit done;
        wr_t e;
        if (mis) q_mis.push_back(1);
        else if (we) begin
            e.addr = {a[31:2], 2'b00}; e.data = ed; e.strb = es;
            q_wr.push_back(e);
            q_done.push_back(last_load);
        end else begin
            q_rd.push_back({a[31:2], 2'b00});
            q_done.push_back(el);
            last_load = el;
        end
        @(posedge clk); #1;
        mem_write_en = we; mem_read_en = re; mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
        #1;
        if (mis) chk("misaligned_stall_low", {31'h0, stall}, 32'd0);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (!stall) done = 1;
        end
        if (!done) chk("timeout_stall", 32'd1, 32'd0);
        idle_inputs();
    endtask

    initial begin
        bit seen;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_write_addr", write_addr, 32'h0);
        chk("rst_read_addr", read_addr, 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        chk("rst_strobe_starts", {26'h0, write_strobe, write_start, read_start}, 32'h0);
        rst = 1'b0;

        //     we  re  f3      addr   wdata         strb     wdata_exp     load_exp      mis
        do_req(1, 0, 3'b010, 32'h04, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD, 32'h0,        0);
        do_req(1, 0, 3'b000, 32'h06, 32'h000000EE, 4'b0100, 32'hEEEEEEEE, 32'h0,        0);
        do_req(0, 1, 3'b010, 32'h04, 32'h0,        4'b0000, 32'h0,        32'hAAEECCDD, 0);
        do_req(1, 0, 3'b010, 32'h04, 32'h80112233, 4'b1111, 32'h80112233, 32'h0,        0);
        do_req(0, 1, 3'b000, 32'h07, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 0);
        do_req(0, 1, 3'b100, 32'h07, 32'h0,        4'b0000, 32'h0,        32'h00000080, 0);
        do_req(0, 1, 3'b001, 32'h06, 32'h0,        4'b0000, 32'h0,        32'hFFFF8011, 0);
        do_req(0, 1, 3'b101, 32'h06, 32'h0,        4'b0000, 32'h0,        32'h00008011, 0);
        do_req(0, 1, 3'b000, 32'h05, 32'h0,        4'b0000, 32'h0,        32'h00000022, 0);
        do_req(1, 0, 3'b001, 32'h02, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0,        0);
        do_req(0, 1, 3'b001, 32'h02, 32'h0,        4'b0000, 32'h0,        32'hFFFFBEEF, 0);
        do_req(0, 1, 3'b010, 32'h05, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        do_req(1, 0, 3'b001, 32'h03, 32'h1234,     4'b0000, 32'h0,        32'h0,        1);
        do_req(1, 1, 3'b010, 32'h08, 32'h12345678, 4'b1111, 32'h12345678, 32'h0,        0);
        do_req(1, 0, 3'b010, 32'h04, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 32'h0,        0);

        // Load interrupted by reset while the master is busy.
        q_rd.push_back(32'h04);
        @(posedge clk); #1;
        mem_read_en = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h04;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (read_busy) seen = 1;
        end
        if (!seen) chk("timeout_read_busy", 32'd1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_stall", {31'h0, stall}, 32'd0);
        chk("post_rst_load_data", load_data, 32'h0);
        last_load = 32'h0;
        do_req(0, 1, 3'b010, 32'h04, 32'h0,        4'b0000, 32'h0,        32'h0BADF00D, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("q_wr_empty", q_wr.size(), 32'd0);
        chk("q_rd_empty", q_rd.size(), 32'd0);
        chk("q_done_empty", q_done.size(), 32'd0);
        chk("q_mis_empty", q_mis.size(), 32'd0);
        chk("write_busy_count", wr_busy_rises, 32'd6);
        chk("read_busy_count", rd_busy_rises, 32'd9);
        chk("mem_word_08", mem[2], 32'h12345678);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
